// File: rtl/core_fetch_s.sv
// Fetch stage: owns the PC, drives the IL1 request/ack handshake and feeds decode
// through a 1-entry skid buffer; exe redirects flush in-flight work.
module core_fetch_s #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fch_enb,
  input  logic        fch_redirect_in,
  input  logic [31:0] fch_redirect_pc_in,
  output logic        fch_il1_req_out,
  output logic [31:0] fch_il1_addr_out,
  input  logic        fch_il1_ack_in,
  input  logic [31:0] fch_il1_data_in,
  output logic [31:0] fch_inst_out_reg,
  output logic [31:0] fch_pc_out_reg,
  output logic [31:0] fch_pc_4_out_reg,
  output logic        fch_nop_gen_out_reg,
  output logic        fch_il1_ack_out_reg,
  output logic        fch_misalign_out_reg
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_drop_addr, r_skid_inst, r_skid_pc;
  logic        r_skid_vld;
  logic        w_req, w_take;

  // A full skid throttles the request so at most one instruction is ever parked.
  assign w_req  = (r_state == S_DROP) || ((r_state == S_REQ) && !r_skid_vld);
  assign w_take = w_req && fch_il1_ack_in && (r_state == S_REQ) && !fch_redirect_in;

  assign fch_il1_req_out  = w_req;
  assign fch_il1_addr_out = (r_state == S_DROP) ? r_drop_addr : r_pc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ:  if (fch_redirect_in && w_req && !fch_il1_ack_in) w_state_nxt = S_DROP;
      S_DROP: if (fch_il1_ack_in) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= S_IDLE;
      r_pc                 <= RESET_PC;
      r_drop_addr          <= '0;
      r_skid_vld           <= 1'b0;
      r_skid_inst          <= NOP_INST;
      r_skid_pc            <= '0;
      fch_inst_out_reg     <= NOP_INST;
      fch_pc_out_reg       <= '0;
      fch_pc_4_out_reg     <= '0;
      fch_nop_gen_out_reg  <= 1'b1;
      fch_il1_ack_out_reg  <= 1'b0;
      fch_misalign_out_reg <= 1'b0;
    end else begin
      r_state              <= w_state_nxt;
      fch_misalign_out_reg <= fch_redirect_in && (fch_redirect_pc_in[1:0] != 2'b00);
      if (fch_redirect_in) begin
        r_pc <= {fch_redirect_pc_in[31:2], 2'b00};
        // Remember the unacked address so the stale request stays stable until IL1 answers.
        if ((r_state == S_REQ) && w_req && !fch_il1_ack_in) r_drop_addr <= r_pc;
        r_skid_vld          <= 1'b0;
        fch_inst_out_reg    <= NOP_INST;
        fch_nop_gen_out_reg <= 1'b1;
        fch_il1_ack_out_reg <= 1'b0;
      end else begin
        if (w_take) r_pc <= r_pc + 32'd4;
        if (r_skid_vld) begin
          if (fch_enb) begin
            fch_inst_out_reg    <= r_skid_inst;
            fch_pc_out_reg      <= r_skid_pc;
            fch_pc_4_out_reg    <= r_skid_pc + 32'd4;
            fch_nop_gen_out_reg <= 1'b0;
            fch_il1_ack_out_reg <= 1'b1;
            r_skid_vld          <= w_take;
            if (w_take) begin
              r_skid_inst <= fch_il1_data_in;
              r_skid_pc   <= r_pc;
            end
          end
        end else if (w_take) begin
          if (!fch_il1_ack_out_reg || fch_enb) begin
            fch_inst_out_reg    <= fch_il1_data_in;
            fch_pc_out_reg      <= r_pc;
            fch_pc_4_out_reg    <= r_pc + 32'd4;
            fch_nop_gen_out_reg <= 1'b0;
            fch_il1_ack_out_reg <= 1'b1;
          end else begin
            r_skid_inst <= fch_il1_data_in;
            r_skid_pc   <= r_pc;
            r_skid_vld  <= 1'b1;
          end
        end else if (fch_enb) begin
          fch_inst_out_reg    <= NOP_INST;
          fch_nop_gen_out_reg <= 1'b1;
          fch_il1_ack_out_reg <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_core_fetch_s.sv
// Bench for core_fetch_s: IL1 latency model, reference PC/drop model and an
// in-order scoreboard of instructions decode should consume.
module tb_core_fetch_s;
  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } sb_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enb = 1'b1, redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        req, ack_in;
  logic [31:0] addr, data_in, inst_o, pc_o, pc4_o;
  logic        nop_o, ack_o, mis_o;

  int          lat = 0;
  int          wcnt = 0;
  int          n_tests = 0, n_fail = 0;

  sb_t         sbq[$];
  logic [31:0] exp_pc = RST_PC, drop_addr = '0;
  logic        dropping = 1'b0, mis_exp = 1'b0;

  always #5 clk = ~clk;

  core_fetch_s dut (
    .clk(clk), .rst_n(rst_n), .fch_enb(enb),
    .fch_redirect_in(redir), .fch_redirect_pc_in(redir_pc),
    .fch_il1_req_out(req), .fch_il1_addr_out(addr),
    .fch_il1_ack_in(ack_in), .fch_il1_data_in(data_in),
    .fch_inst_out_reg(inst_o), .fch_pc_out_reg(pc_o), .fch_pc_4_out_reg(pc4_o),
    .fch_nop_gen_out_reg(nop_o), .fch_il1_ack_out_reg(ack_o),
    .fch_misalign_out_reg(mis_o)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // IL1: acks a request after lat waiting cycles (lat=0 -> same cycle)
  assign ack_in  = req && (wcnt >= lat);
  assign data_in = memf(addr);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 0;
    else        wcnt <= (!req || ack_in) ? 0 : wcnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model evaluated mid-cycle for the edge that follows
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      exp_pc = RST_PC; dropping = 1'b0; mis_exp = 1'b0;
    end else begin
      sb_t e;
      chk("misalign", {31'd0, mis_o}, {31'd0, mis_exp});
      mis_exp = redir && (redir_pc[1:0] != 2'b00);
      chk("nop_vs_ack", {31'd0, nop_o}, {31'd0, !ack_o});
      if (!ack_o) chk("bubble_inst", inst_o, NOP);
      if (ack_o && enb) begin
        if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("out_pc", pc_o, e.pc);
          chk("out_inst", inst_o, e.inst);
          chk("out_pc4", pc4_o, e.pc + 32'd4);
        end
      end
      if (req) chk("il1_addr", addr, dropping ? drop_addr : exp_pc);
      if (req && ack_in) begin
        if (dropping || redir) dropping = 1'b0;
        else begin
          sbq.push_back('{pc: exp_pc, inst: memf(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redir) begin
        sbq.delete();
        if (req && !ack_in && !dropping) begin
          dropping = 1'b1; drop_addr = exp_pc;
        end
        exp_pc = {redir_pc[31:2], 2'b00};
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [31:0] hold, old_addr;
  logic        found;

  initial begin
    // 0: reset values
    step(); step();
    @(negedge clk);
    chk("rst_inst", inst_o, NOP);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_pc4", pc4_o, 32'd0);
    chk("rst_nop", {31'd0, nop_o}, 32'd1);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_mis", {31'd0, mis_o}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);

    // 1: back-to-back fetch
    step(); rst_n = 1'b1;
    step();
    @(negedge clk); chk("t1_req", {31'd0, req}, 32'd1); chk("t1_a0", addr, 32'h200);
    step();
    @(negedge clk); chk("t1_a1", addr, 32'h204); chk("t1_pc0", pc_o, 32'h200);
    chk("t1_nop", {31'd0, nop_o}, 32'd0);
    step();
    @(negedge clk); chk("t1_a2", addr, 32'h208); chk("t1_pc1", pc_o, 32'h204);

    // 2: ack delayed 3 cycles
    step(); rst_n = 1'b0; lat = 3;
    step(); rst_n = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("t2_addr", addr, 32'h200); chk("t2_bub", {31'd0, ack_o}, 32'd0);
      step();
    end
    @(negedge clk); chk("t2_pc", pc_o, 32'h200); chk("t2_ack", {31'd0, ack_o}, 32'd1);

    // 3: decode stall with continuous ack
    lat = 0;
    repeat (4) step();
    enb = 1'b0;
    @(negedge clk); hold = pc_o; chk("t3_full", {31'd0, ack_o}, 32'd1);
    step();
    @(negedge clk); chk("t3_req_drop", {31'd0, req}, 32'd0); chk("t3_hold1", pc_o, hold);
    step();
    @(negedge clk); chk("t3_hold2", pc_o, hold);
    step(); enb = 1'b1;
    @(negedge clk); chk("t3_hold3", pc_o, hold);
    step();
    @(negedge clk); chk("t3_skid", pc_o, hold + 32'd4);
    repeat (3) step();

    // 4: redirect over an unacked request
    lat = 6;
    step();
    redir = 1'b1; redir_pc = 32'h1000;
    @(negedge clk); old_addr = addr; chk("t4_pend", {31'd0, req}, 32'd1);
    step(); redir = 1'b0; lat = 1;
    @(negedge clk); chk("t4_bub", {31'd0, ack_o}, 32'd0); chk("t4_old", addr, old_addr);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      @(negedge clk);
      if (req && addr == 32'h1000) found = 1'b1;
    end
    chk("t4_newaddr", {31'd0, found}, 32'd1);
    repeat (4) step();

    // 5: misaligned redirect and PC wrap
    lat = 0;
    step(); step();
    redir = 1'b1; redir_pc = 32'h1002;
    step(); redir = 1'b0;
    @(negedge clk); chk("t5_mis1", {31'd0, mis_o}, 32'd1); chk("t5_a", addr, 32'h1000);
    step();
    @(negedge clk); chk("t5_mis0", {31'd0, mis_o}, 32'd0); chk("t5_a4", addr, 32'h1004);
    step(); redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    step(); redir = 1'b0;
    @(negedge clk); chk("t5_wa", addr, 32'hFFFF_FFFC);
    step();
    @(negedge clk); chk("t5_wrap", addr, 32'h0); chk("t5_wpc", pc_o, 32'hFFFF_FFFC);
    chk("t5_wpc4", pc4_o, 32'h0);

    // 6: reset mid-request
    lat = 5;
    step(); step();
    rst_n = 1'b0;
    #1; chk("t6_req", {31'd0, req}, 32'd0); chk("t6_nop", {31'd0, nop_o}, 32'd1);
    chk("t6_ack", {31'd0, ack_o}, 32'd0);
    step(); rst_n = 1'b1; lat = 0;
    step();
    @(negedge clk); chk("t6_addr", addr, RST_PC); chk("t6_req1", {31'd0, req}, 32'd1);

    // Random stalls, latencies and redirects against the model
    for (int k = 0; k < 400; k++) begin
      step();
      enb      = ($urandom_range(0, 3) != 0);
      lat      = $urandom_range(0, 2);
      redir    = ($urandom_range(0, 15) == 0);
      redir_pc = $urandom();
    end
    step(); redir = 1'b0; enb = 1'b1; lat = 0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
